ixc_sample_sched: RTL and testbench
===================================

Name: ixc_sample_sched

Overview:
- Scheduler for the sampling latch bank of the emulation sample logic.
- Several requesters share the bank: emulator call-pre, host sample override, trigger unit and debug port.
- Block arbitrates round-robin and opens the latch gate for a fixed settle window.
- Acknowledges the winner, counts completed samples and reports busy status to the host.

Parameters:
- NUM_REQ, 4, number of sample requesters (2..8).
- SETTLE_CYC, 2, cycles sample_g is held high per sample (1..15).
- CNT_W, 16, width of the completed-sample counter.

Ports:
- clk  input  1  design clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester sample request; level, held until ack.
- stall  input  1  when high, no new grant is issued; an in-progress sample completes.
- cnt_clr  input  1  synchronous clear of sample_cnt.
- ack  output  NUM_REQ  one-hot, one-cycle pulse to the granted requester on sample completion.
- grant_id  output  clog2(NUM_REQ)  index of the current/last granted requester.
- sample_g  output  1  latch gate enable to the sample bank (drives the latch G input).
- busy  output  1  high in any state other than IDLE.
- sample_cnt  output  CNT_W  number of completed samples; saturating.

Behaviour:
- Reset values (async, immediate): state=IDLE, sample_g=0, ack=0, busy=0, grant_id=0, rr pointer=0, sample_cnt=0, settle counter=0.
- All outputs are registered. No combinational path from req to any output.
- FSM states: IDLE, OPEN, CLOSE.
- IDLE:
  - If |req and !stall: pick the winner round-robin, starting search at the rr pointer.
  - Latch grant_id = winner; set rr pointer = (winner+1) mod NUM_REQ.
  - Load settle counter = SETTLE_CYC-1; go to OPEN.
  - Otherwise stay in IDLE.
- OPEN:
  - sample_g=1 for exactly SETTLE_CYC cycles.
  - Settle counter decrements each cycle; at 0, go to CLOSE.
- CLOSE:
  - sample_g=0; ack[grant_id]=1 for this single cycle.
  - sample_cnt increments, saturating at all-ones; go to IDLE.
- Latency: req high in IDLE in cycle t.
  - sample_g high for cycles t+1..t+SETTLE_CYC.
  - ack in cycle t+SETTLE_CYC+1.
  - Earliest next grant is in cycle t+SETTLE_CYC+2, giving a back-to-back period of SETTLE_CYC+2.
- Requester holds req until it sees ack.
  - If req drops before ack, the sample still completes and ack still pulses.
  - The requester ignores that ack.
- The rr pointer advances only on grant. With a single active requester, it is regranted every period.
- stall is sampled only in IDLE. Asserting stall during OPEN/CLOSE has no effect on the current sample.
- cnt_clr:
  - Clears sample_cnt next edge.
  - If cnt_clr coincides with the CLOSE increment, clear wins and the result is 0.
- Saturation: at all-ones, further completions leave sample_cnt unchanged; ack still pulses.
- Reset mid-OPEN: sample_g drops immediately (async), no ack is issued and the count is unchanged.
- grant_id holds its value through IDLE until the next grant.

Optional Feature:
- Macro IXC_SAMPLE_OVR_EN.
- When defined:
  - Adds input port ovr (1 bit), the transparent-override request.
  - sample_g = FSM gate OR a registered copy of ovr, so it follows ovr with 1-cycle latency.
  - While ovr is high, IDLE issues no grants; an in-progress sample completes normally.
  - busy = (state!=IDLE) | ovr_q.
  - Override cycles do not increment sample_cnt and produce no ack.
- When undefined:
  - No ovr port; sample_g is driven by the FSM only.

Test Plan:
- Reset, then req=4'b0001 held, SETTLE_CYC=2, grant in cycle 0 -> sample_g high cycles 1-2, ack=4'b0001 in cycle 3, sample_cnt=1, busy low in cycle 4.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0; ack pulse every 4 cycles; sample_cnt=5 after 5 samples.
- stall=1 with req=4'b0010 -> no sample_g for 20 cycles. Release stall -> sample_g rises the next cycle; stall raised mid-OPEN still yields ack.
- Preload sample_cnt to 16'hFFFF via 65535 samples (or force) -> one more sample keeps 16'hFFFF with ack pulse. cnt_clr coincident with CLOSE -> sample_cnt=0.
- rst asserted during OPEN cycle 1 -> sample_g=0 in the same cycle, no ack; after release req=4'b0100 -> grant_id=2 and rr pointer restarts from 0.
- With IXC_SAMPLE_OVR_EN: ovr=1 for 5 cycles while req=4'b0001 -> sample_g high 5 cycles (1-cycle lag), no ack, sample_cnt unchanged; after ovr drops, normal grant follows.

Source files
------------

// File: rtl/ixc_sample_sched_if.sv
// Handshake bundle between the sample requesters/host and the latch-bank scheduler.
// The ovr signal exists only when IXC_SAMPLE_OVR_EN is defined.
interface ixc_sample_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a requester holds its req bit (level) until it sees its one-cycle
  // ack bit; ack always pulses for a started sample, even if req has been dropped.
  logic [NUM_REQ-1:0] req;
  logic               stall;
  logic               cnt_clr;
`ifdef IXC_SAMPLE_OVR_EN
  logic               ovr;
`endif
  logic [NUM_REQ-1:0] ack;
  logic [ID_W-1:0]    grant_id;
  logic               sample_g;
  logic               busy;
  logic [CNT_W-1:0]   sample_cnt;
  logic [1:0]         state;

`ifdef IXC_SAMPLE_OVR_EN
  modport master (output req, stall, cnt_clr, ovr,
                  input  ack, grant_id, sample_g, busy, sample_cnt, state);
  modport slave  (input  req, stall, cnt_clr, ovr,
                  output ack, grant_id, sample_g, busy, sample_cnt, state);
`else
  modport master (output req, stall, cnt_clr,
                  input  ack, grant_id, sample_g, busy, sample_cnt, state);
  modport slave  (input  req, stall, cnt_clr,
                  output ack, grant_id, sample_g, busy, sample_cnt, state);
`endif
endinterface

// File: rtl/ixc_sample_sched.sv
// Round-robin scheduler for the sampling latch bank: grants one requester, holds the
// latch gate for SETTLE_CYC cycles, then acks. Optional override: IXC_SAMPLE_OVR_EN.
module ixc_sample_sched #(
  parameter int NUM_REQ    = 4,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  ixc_sample_sched_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, OPEN = 2'd1, CLOSE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [3:0]           settle_q, settle_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      winner;
  logic                 found;
  logic                 grant_ok;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 gate_q, gate_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

`ifdef IXC_SAMPLE_OVR_EN
  logic ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= bus.ovr;
  end

  assign grant_ok     = !bus.stall && !bus.ovr;
  assign bus.sample_g = gate_q | ovr_q;
  assign bus.busy     = busy_q | ovr_q;
`else
  assign grant_ok     = !bus.stall;
  assign bus.sample_g = gate_q;
  assign bus.busy     = busy_q;
`endif

  assign bus.ack        = ack_q;
  assign bus.grant_id   = id_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.state      = state_q;

  // Rotate requests so bit 0 is the requester at the rr pointer; first set bit wins.
  assign req_dbl = {bus.req, bus.req} >> ptr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    int sum;
    found  = 1'b0;
    winner = '0;
    sum    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = int'(ptr_q) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        winner = ID_W'(sum);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      ptr_q    <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    case (state_q)
      IDLE: begin
        if (found && grant_ok) begin
          state_d  = OPEN;
          id_d     = winner;
          ptr_d    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          settle_d = 4'(SETTLE_CYC - 1);
        end
      end
      OPEN: begin
        if (settle_q == 4'd0) state_d = CLOSE;
        else                  settle_d = settle_q - 4'd1;
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every output pin comes from a flop.
  always_comb begin
    gate_d = (state_d == OPEN);
    busy_d = (state_d != IDLE);
    ack_d  = '0;
    if (state_d == CLOSE) ack_d[id_d] = 1'b1;
    cnt_d = cnt_q;
    if (bus.cnt_clr)                             cnt_d = '0;
    else if (state_q == CLOSE && cnt_q != '1)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_q <= 1'b0;
      busy_q <= 1'b0;
      ack_q  <= '0;
      cnt_q  <= '0;
    end else begin
      gate_q <= gate_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ixc_sample_sched.sv
// Bench for ixc_sample_sched: directed phases with an ack scoreboard, plus a narrow
// counter instance for saturation.
module tb_ixc_sample_sched;
  localparam int NUM_REQ = 4;
  localparam int SETTLE  = 2;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   gate_run = 0;
  int   last_ack_cyc = 0;
  logic [NUM_REQ-1:0] exp_q[$];

  ixc_sample_sched_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();
  ixc_sample_sched_if #(.NUM_REQ(NUM_REQ), .CNT_W(4))     sat_bus ();

  ixc_sample_sched #(.NUM_REQ(NUM_REQ), .SETTLE_CYC(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  ixc_sample_sched #(.NUM_REQ(NUM_REQ), .SETTLE_CYC(SETTLE), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(sat_bus.slave));

  // clock / reset
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // scoreboard monitor: every ack must match the next expected grant
  initial forever begin
    logic [NUM_REQ-1:0] exp_v;
    @(negedge clk);
    if (!rst) begin
      if (bus.ack != '0) begin
        if (exp_q.size() == 0) chk("ack_unexpected", 32'(bus.ack), 0);
        else begin
          exp_v = exp_q.pop_front();
          chk("ack", 32'(bus.ack), 32'(exp_v));
        end
        chk("settle_len", gate_run, SETTLE);
        last_ack_cyc = cyc;
        gate_run = 0;
      end else if (bus.sample_g) gate_run++;
      else gate_run = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    errs++;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    int start;
    int highs;
    bus.req = '0; bus.stall = 1'b0; bus.cnt_clr = 1'b0;
    sat_bus.req = '0; sat_bus.stall = 1'b0; sat_bus.cnt_clr = 1'b0;
`ifdef IXC_SAMPLE_OVR_EN
    bus.ovr = 1'b0; sat_bus.ovr = 1'b0;
`endif
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_gate", 32'(bus.sample_g), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_cnt", 32'(bus.sample_cnt), 0);

    // single requester latency
    do_reset();
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    @(negedge clk) chk("t1_c0_gate", 32'(bus.sample_g), 0);
    tick();
    @(negedge clk);
    chk("t1_c1_gate", 32'(bus.sample_g), 1);
    chk("t1_c1_busy", 32'(bus.busy), 1);
    chk("t1_c1_id", 32'(bus.grant_id), 0);
    tick();
    @(negedge clk) chk("t1_c2_gate", 32'(bus.sample_g), 1);
    tick();
    @(negedge clk);
    chk("t1_c3_gate", 32'(bus.sample_g), 0);
    chk("t1_c3_ack", 32'(bus.ack), 32'h1);
    bus.req = '0;
    tick();
    @(negedge clk);
    chk("t1_c4_busy", 32'(bus.busy), 0);
    chk("t1_c4_cnt", 32'(bus.sample_cnt), 1);
    chk("t1_c4_ack", 32'(bus.ack), 0);

    // all requesters: round-robin 0,1,2,3,0 with period SETTLE+2
    do_reset();
    start = cyc;
    bus.req = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    wait_drain("t2_drain");
    bus.req = '0;
    chk("t2_last_ack_cyc", last_ack_cyc - start, 4 * (SETTLE + 2) + SETTLE + 1);
    @(negedge clk) chk("t2_cnt", 32'(bus.sample_cnt), 5);
    tick();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    @(negedge clk) chk("t2_cnt_clr", 32'(bus.sample_cnt), 0);

    // stall blocks grants; stall mid-OPEN does not abort
    tick();
    bus.stall = 1'b1;
    bus.req = 4'b0010;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.sample_g || bus.busy) highs++;
    end
    chk("t3_stall_idle", highs, 0);
    tick();
    bus.stall = 1'b0;
    exp_q.push_back(4'b0010);
    @(negedge clk) chk("t3_rel_c0_gate", 32'(bus.sample_g), 0);
    tick();
    @(negedge clk) chk("t3_rel_c1_gate", 32'(bus.sample_g), 1);
    bus.stall = 1'b1;
    wait_drain("t3_drain");
    bus.req = '0;
    bus.stall = 1'b0;
    @(negedge clk) chk("t3_grant_id", 32'(bus.grant_id), 1);

    // saturation on the 4-bit counter instance
    do_reset();
    sat_bus.req = 4'b0001;
    repeat (60) tick();
    @(negedge clk) chk("t4_sat_full", 32'(sat_bus.sample_cnt), 32'hF);
    repeat (3) tick();
    @(negedge clk);
    chk("t4_sat_ack", 32'(sat_bus.ack), 32'h1);
    chk("t4_sat_hold", 32'(sat_bus.sample_cnt), 32'hF);
    sat_bus.req = '0;
    tick();
    @(negedge clk) chk("t4_sat_after", 32'(sat_bus.sample_cnt), 32'hF);

    // cnt_clr coincident with CLOSE: clear wins
    tick();
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    repeat (3) tick();
    bus.cnt_clr = 1'b1;
    bus.req = '0;
    tick();
    bus.cnt_clr = 1'b0;
    @(negedge clk) chk("t4_clr_close", 32'(bus.sample_cnt), 0);
    wait_drain("t4_drain");

    // reset mid-OPEN: gate drops immediately, rr pointer restarts from 0
    tick();
    bus.req = 4'b0010;
    tick();
    @(negedge clk);
    chk("t5_open_gate", 32'(bus.sample_g), 1);
    chk("t5_open_id", 32'(bus.grant_id), 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_gate", 32'(bus.sample_g), 0);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    bus.req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.req = 4'b0110;
    exp_q.push_back(4'b0010);
    wait_drain("t5_drain_a");
    bus.req = 4'b0100;
    @(negedge clk) chk("t5_rr_restart", 32'(bus.grant_id), 1);
    exp_q.push_back(4'b0100);
    wait_drain("t5_drain_b");
    bus.req = '0;
    @(negedge clk);
    chk("t5_grant_id", 32'(bus.grant_id), 2);
    chk("t5_cnt", 32'(bus.sample_cnt), 2);

`ifdef IXC_SAMPLE_OVR_EN
    // transparent override: gate follows ovr, no grant, no ack, count unchanged
    do_reset();
    bus.req = 4'b0001;
    bus.ovr = 1'b1;
    highs = 0;
    @(negedge clk) chk("t6_ovr_c0", 32'(bus.sample_g), 0);
    repeat (5) begin
      tick();
      @(negedge clk);
      if (bus.sample_g) highs++;
      if (highs == 5) bus.ovr = 1'b0;
    end
    bus.ovr = 1'b0;
    bus.req = '0;
    repeat (3) begin
      tick();
      @(negedge clk);
      if (bus.sample_g) highs++;
    end
    chk("t6_ovr_highs", highs, 5);
    chk("t6_ovr_cnt", 32'(bus.sample_cnt), 0);
    tick();
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_drain("t6_drain");
    bus.req = '0;
    @(negedge clk) chk("t6_cnt", 32'(bus.sample_cnt), 1);
`endif

    repeat (3) tick();
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
